pc_unit: RTL

//   Parametrised fetch program counter for the RV32i core. Generates the fetch PC and

---
 rtl/pc_unit_if.sv | 29 ++
 rtl/pc_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch PC unit bus: control requests from the core and the PC/history it gets back.
//   master: drives stall/redirect/trap/mret, receives PC, history, epc, misaligned pulse
//   slave : the pc_unit side
interface pc_unit_if #(
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned PIPE_DEPTH     = 2
);
    logic                                 stall_i;
    logic                                 redirect_i;
    logic [REG_DATA_WIDTH-1:0]            redirect_pc_i;
    logic                                 trap_i;
    logic                                 mret_i;
    logic [REG_DATA_WIDTH-1:0]            pc_o;
    logic                                 pc_valid_o;
    logic [PIPE_DEPTH*REG_DATA_WIDTH-1:0] pc_pipe_o;
    logic [PIPE_DEPTH-1:0]                pc_pipe_valid_o;
    logic [REG_DATA_WIDTH-1:0]            epc_o;
    logic                                 misaligned_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, trap_i, mret_i,
        input  pc_o, pc_valid_o, pc_pipe_o, pc_pipe_valid_o, epc_o, misaligned_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, trap_i, mret_i,
        output pc_o, pc_valid_o, pc_pipe_o, pc_pipe_valid_o, epc_o, misaligned_o
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter for the RV32i core.
// Chooses the next fetch PC (trap > mret > redirect > stall > +4), traps misaligned
// redirect targets to TRAP_VECTOR, and keeps a PIPE_DEPTH-deep history of issued PCs
// with valid bits so later stages know their instruction's PC and whether it was squashed.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - synchronous reset, active low
//   bus   - pc_unit_if slave: stall/redirect/trap/mret in; pc, pc_valid, pc_pipe,
//           pc_pipe_valid, epc, misaligned out
module pc_unit #(
    parameter int unsigned                REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0]  RESET_VECTOR   = '0,
    parameter logic [REG_DATA_WIDTH-1:0]  TRAP_VECTOR    = REG_DATA_WIDTH'(32'h100),
    parameter int unsigned                PIPE_DEPTH     = 2,
    parameter int unsigned                ALIGN_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);
    localparam int unsigned W = REG_DATA_WIDTH;
    // ALIGN_BITS == 0 gives an all-zero mask, so no redirect ever counts as misaligned.
    localparam logic [W-1:0] AlignMask =
        (ALIGN_BITS == 0) ? '0 : ((W'(1) << ALIGN_BITS) - W'(1));

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e                      state_q;
    logic [W-1:0]                pc_q, pc_d;
    logic [W-1:0]                epc_q, epc_d;
    logic [PIPE_DEPTH-1:0][W-1:0] pipe_q, pipe_d;
    logic [PIPE_DEPTH-1:0]       pvld_q, pvld_d;
    logic                        pc_valid_q;
    logic                        mis_q, mis_d;
    logic                        misalign;
    logic                        ctl_flow;
    logic                        advance;

    always_comb begin
        misalign = |(bus.redirect_pc_i & AlignMask);
        ctl_flow = bus.trap_i | bus.mret_i | bus.redirect_i;
        // Any control-flow change overrides stall, so history still shifts.
        advance  = ctl_flow | ~bus.stall_i;

        pc_d  = pc_q;
        epc_d = epc_q;
        mis_d = 1'b0;
        if (bus.trap_i) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
        end else if (bus.mret_i) begin
            pc_d = epc_q;
        end else if (bus.redirect_i && misalign) begin
            pc_d  = TRAP_VECTOR;
            epc_d = bus.redirect_pc_i;
            mis_d = 1'b1;
        end else if (bus.redirect_i) begin
            pc_d = bus.redirect_pc_i;
        end else if (!bus.stall_i) begin
            pc_d = pc_q + W'(4);
        end

        pipe_d = pipe_q;
        pvld_d = pvld_q;
        if (advance) begin
            pipe_d[0] = pc_q;
            // The fetch at pc_q is squashed whenever control flow changes.
            pvld_d[0] = ~ctl_flow;
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                pipe_d[k] = pipe_q[k-1];
                pvld_d[k] = pvld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pipe_q     <= '0;
            pvld_q     <= '0;
            pc_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // One idle cycle; PC held and all control inputs ignored.
                    state_q    <= StRun;
                    pc_valid_q <= 1'b1;
                end
                StRun: begin
                    pc_q   <= pc_d;
                    epc_q  <= epc_d;
                    pipe_q <= pipe_d;
                    pvld_q <= pvld_d;
                    mis_q  <= mis_d;
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.pc_valid_o      = pc_valid_q;
    assign bus.pc_pipe_o       = pipe_q;
    assign bus.pc_pipe_valid_o = pvld_q;
    assign bus.epc_o           = epc_q;
    assign bus.misaligned_o    = mis_q;
endmodule
